bitonic_sorter_input_packer: RTL
================================

// Module: bitonic_sorter_input_packer
// PURPOSE
//   Upstream stage of bitonic_sorter_16. Packs a serial stream of SINGLE_WAY_WIDTH_IN_BITS
//   keys into one NUM_WAY-wide flattened vector. Short batches are padded. The vector is
//   handed to the sorter wrapper over a valid/ready handshake.
//   Holds one batch filling and one batch presented, so input streaming continues
//   while the sorter side back-pressures.
// PARAMETERS
//   SINGLE_WAY_WIDTH_IN_BITS  4                 width of one key
//   NUM_WAY                   16                keys per batch; power of 2, >= 2
//   PAD_VALUE                 {W{1'b1}}         key written into unfilled ways on flush (sorts last ascending)
//   CNT_W                     $clog2(NUM_WAY)+1 width of way counters
// PORTS
//   clk_in                clk_in                input   1          single clock, rising edge
//   reset_in              reset_in              input   1          asynchronous, active-low (0 = reset)
//   data_in               data_in               input   W          key to pack
//   data_valid_in         data_valid_in         input   1          data_in valid
//   data_ready_out        data_ready_out        output  1          packer can accept data_in
//   flush_in              flush_in              input   1          close current partial batch (1-cycle pulse)
//   packed_flatted_out    packed_flatted_out    output  W*NUM_WAY  batch; way i at [i*W +: W]
//   packed_valid_out      packed_valid_out      output  1          batch presented
//   packed_ready_in       packed_ready_in       input   1          sorter side takes batch
//   packed_count_out      packed_count_out      output  CNT_W      real (non-pad) keys in batch, 1..NUM_WAY
// BEHAVIOUR
// - Reset (reset_in=0, any time, async): fill count=0, fill buffer cleared, packed_valid_out=0,
//   packed_flatted_out=0, packed_count_out=0, data_ready_out=0 while in reset. In-flight data is discarded.
// - Accept: the key is accepted when data_valid_in && data_ready_out at the clock edge.
//   - The k-th accepted key of a batch (k from 0) is written to way k. The fill count then increments.
// - data_ready_out = 1 when either holds:
//   - the fill buffer is not closed;
//   - the fill buffer is closed and the output register is empty or being consumed this cycle.
// - The batch closes in either case:
//   - the key that makes fill count reach NUM_WAY is accepted;
//   - flush_in=1 while fill count (including any key accepted the same cycle) >= 1.
// - flush_in with an empty fill buffer and no same-cycle accept: no-op, no batch emitted.
// - flush_in with a same-cycle accept: the key is included, then the batch closes.
// - On close, ways k..NUM_WAY-1 take PAD_VALUE.
//   - packed_count_out = number of real keys; it never equals 0 while valid.
// - Transfer: a closed batch moves to the output register on the edge where the register is
//   empty or handshaken (packed_valid_out && packed_ready_in).
//   - Otherwise the batch stays closed and data_ready_out=0 until the transfer happens.
//   - After transfer, the fill count is 0.
// - Latency: the batch closes at edge N -> packed_valid_out=1 after edge N if the register is free.
//   - Full-rate streaming, ready held high: one batch every NUM_WAY cycles, no bubbles.
// - Output stability: while packed_valid_out=1 && !packed_ready_in, packed_flatted_out and
//   packed_count_out stay constant.
// - Handshake and transfer on the same edge: the register loads the new batch; packed_valid_out stays 1.
// - Handshake without a pending batch: packed_valid_out -> 0.
//   - packed_flatted_out holds its last value; don't-care to the consumer.
// - flush_in while a batch is closed and pending: ignored, no second close.
//   - Data keys may still fill the next batch only after the transfer.
// - Counters never wrap. The fill count saturates at NUM_WAY by construction; keys are never overwritten or dropped.
// STRUCTURE
// - Shared constants go in parameters.h: defaults for SINGLE_WAY_WIDTH_IN_BITS, NUM_WAY, PAD_VALUE.
// - Fill buffer, count, closed flag and output register live in this module.
// - Natural sub-module: sorter_batch_register, a W*NUM_WAY + CNT_W valid/ready holding register
//   used for the output stage.
// TESTING
// - Reset low mid-fill (5 keys in) -> packed_valid_out=0, next 16 keys form a clean batch, no stale ways.
// - Stream keys 0xf..0x0, ready=1 -> one batch, way0=0xf..way15=0x0, packed_count_out=16, valid 1 cycle after last key.
// - 3 keys 0x2,0x9,0x4 then flush_in -> ways0-2 = 2,9,4, ways3-15=0xf, count=3.
//   - flush_in again with empty buffer -> nothing.
// - packed_ready_in=0, stream 40 keys -> batch1 held stable, batch2 closes, data_ready_out=0 after key 32.
//   - ready=1 for one cycle -> batch2 presented same edge, keys 33-40 accepted.
// - Continuous 64 keys, data_valid_in and packed_ready_in =1 -> 4 batches, data_ready_out never drops, no bubbles.
// - Key accepted with flush_in at count 15 -> full batch, count=16, no padding.
//   - Output to bitonic_sorter_16 -> ascending result.

Source files
------------

// File: rtl/bitonic_sorter_input_packer_pkg.sv
// rtl/bitonic_sorter_input_packer_pkg.sv - shared defaults for the bitonic sorter input packer
package bitonic_sorter_input_packer_pkg;

    localparam int DEFAULT_WAY_W   = 4;
    localparam int DEFAULT_NUM_WAY = 16;

    function automatic int cnt_width(input int num_way);
        return $clog2(num_way) + 1;
    endfunction

endpackage

// File: rtl/bitonic_sorter_input_packer_batch_register.sv
// rtl/bitonic_sorter_input_packer_batch_register.sv - valid/ready holding register for one packed batch
module sorter_batch_register #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 5
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              load_valid_in,
    input  logic [DATA_W-1:0] load_data_in,
    input  logic [CNT_W-1:0]  load_count_in,
    output logic              load_ready_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  count_out,
    input  logic              ready_in
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              load;

    assign load_ready_out = !valid_q || ready_in;
    assign load           = load_valid_in && load_ready_out;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data_in;
            count_d = load_count_in;
        end else if (ready_in) begin
            // data/count keep their last value; only valid drops
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign count_out = count_q;

endmodule

// File: rtl/bitonic_sorter_input_packer.sv
// rtl/bitonic_sorter_input_packer.sv - packs a serial key stream into padded NUM_WAY-wide batches
module bitonic_sorter_input_packer
    import bitonic_sorter_input_packer_pkg::*;
#(
    parameter int SINGLE_WAY_WIDTH_IN_BITS = DEFAULT_WAY_W,
    parameter int NUM_WAY                  = DEFAULT_NUM_WAY,
    parameter logic [SINGLE_WAY_WIDTH_IN_BITS-1:0] PAD_VALUE = {SINGLE_WAY_WIDTH_IN_BITS{1'b1}},
    parameter int CNT_W                    = cnt_width(NUM_WAY)
) (
    input  logic                                        clk_in,
    input  logic                                        reset_in,
    input  logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]         data_in,
    input  logic                                        data_valid_in,
    output logic                                        data_ready_out,
    input  logic                                        flush_in,
    output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] packed_flatted_out,
    output logic                                        packed_valid_out,
    input  logic                                        packed_ready_in,
    output logic [CNT_W-1:0]                            packed_count_out
);

    localparam int W     = SINGLE_WAY_WIDTH_IN_BITS;
    localparam int IDX_W = $clog2(NUM_WAY);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_WAY);

    logic [NUM_WAY-1:0][W-1:0] fill_buf_q, fill_buf_d, buf_next;
    logic [CNT_W-1:0]          fill_cnt_q, fill_cnt_d;
    logic                      closed_q, closed_d;

    logic                      reg_free;
    logic                      accept;
    logic                      xfer_pending;
    logic                      close_now;
    logic [CNT_W-1:0]          base_cnt, cnt_next;
    logic                      load_valid;
    logic [W*NUM_WAY-1:0]      load_data;
    logic [CNT_W-1:0]          load_count;

    assign data_ready_out = reset_in && (!closed_q || reg_free);
    assign accept         = data_valid_in && data_ready_out;

    always_comb begin
        xfer_pending = closed_q && reg_free;
        // a pending batch leaving this edge frees the fill buffer for a key at way 0
        base_cnt     = xfer_pending ? '0 : fill_cnt_q;
        cnt_next     = base_cnt + CNT_W'(accept);
        buf_next     = fill_buf_q;
        if (accept) begin
            buf_next[base_cnt[IDX_W-1:0]] = data_in;
        end
        close_now = !closed_q && ((cnt_next == FULL_CNT) || (flush_in && (cnt_next != '0)));
        if (close_now) begin
            for (int i = 0; i < NUM_WAY; i++) begin
                if (CNT_W'(i) >= cnt_next) begin
                    buf_next[i] = PAD_VALUE;
                end
            end
        end

        // closing into a free register bypasses the closed state for zero-bubble streaming
        load_valid = xfer_pending || (close_now && reg_free);
        load_data  = xfer_pending ? fill_buf_q : buf_next;
        load_count = xfer_pending ? fill_cnt_q : cnt_next;

        fill_buf_d = buf_next;
        fill_cnt_d = cnt_next;
        closed_d   = closed_q;
        if (xfer_pending) begin
            closed_d = 1'b0;
        end else if (close_now && reg_free) begin
            fill_cnt_d = '0;
        end else if (close_now) begin
            closed_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            fill_buf_q <= '0;
            fill_cnt_q <= '0;
            closed_q   <= 1'b0;
        end else begin
            fill_buf_q <= fill_buf_d;
            fill_cnt_q <= fill_cnt_d;
            closed_q   <= closed_d;
        end
    end

    sorter_batch_register #(
        .DATA_W (W * NUM_WAY),
        .CNT_W  (CNT_W)
    ) u_out_reg (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .load_valid_in  (load_valid),
        .load_data_in   (load_data),
        .load_count_in  (load_count),
        .load_ready_out (reg_free),
        .valid_out      (packed_valid_out),
        .data_out       (packed_flatted_out),
        .count_out      (packed_count_out),
        .ready_in       (packed_ready_in)
    );

endmodule
